regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (W_addr, W_data, wr_enable) between two writeback sources.
  - Source A: the in-order pipeline writeback. It has fixed priority and no handshake.
  - Source B: the long-latency unit (mul/div/load). It uses a valid/ready handshake and is buffered in a small FIFO.
- Also exports a per-register pending mask so the pipeline can detect hazards against queued B writes.
- Issues a stall request when B entries starve.

---
 rtl/regfile_wb_arbiter_if.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the pipeline/long-latency unit and the regfile arbiter.
interface regfile_wb_arbiter_if #(
  parameter int width = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             a_valid;
  logic [4:0]       a_addr;
  logic [width-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [4:0]       b_addr;
  logic [width-1:0] b_data;
  logic [4:0]       W_addr;
  logic [width-1:0] W_data;
  logic             wr_enable;
  logic [31:0]      pending_mask;
  logic [CW-1:0]    fifo_count;
  logic             stall_req;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  b_ready, W_addr, W_data, wr_enable, pending_mask, fifo_count, stall_req
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output b_ready, W_addr, W_data, wr_enable, pending_mask, fifo_count, stall_req
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between the fixed-priority pipeline writeback (A)
// and a FIFO-buffered long-latency writeback (B), with hazard mask and starvation stall.
module regfile_wb_arbiter #(
  parameter int width        = 64,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [4:0]       addr_mem [DEPTH];
  logic [width-1:0] data_mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;
  logic             wen_q, wen_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [width-1:0] wdata_q, wdata_d;
  logic             full, empty, push, a_win, pop;
  logic [AW-1:0]    slot_off;
  logic [31:0]      mask;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // b_ready looks only at current occupancy; zero-address pushes are acked but dropped
  assign push  = bus.b_valid && !full && (bus.b_addr != '0);
  assign a_win = bus.a_valid && (bus.a_addr != '0);
  assign pop   = !a_win && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (a_win) begin
      wen_d   = 1'b1;
      waddr_d = bus.a_addr;
      wdata_d = bus.a_data;
    end else if (pop) begin
      wen_d    = 1'b1;
      waddr_d  = addr_mem[rd_ptr_q[AW-1:0]];
      wdata_d  = data_mem[rd_ptr_q[AW-1:0]];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Non-empty without a pop means A took the port this cycle
    if (empty || pop)        starve_d = '0;
    else if (starve_q != LIMIT) starve_d = starve_q + 1'b1;
    stall_d = (starve_d == LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q[AW-1:0]] <= bus.b_addr;
      data_mem[wr_ptr_q[AW-1:0]] <= bus.b_data;
    end
  end

  // Slot is occupied when its distance from the head is below the count
  always_comb begin
    mask     = '0;
    slot_off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_off = AW'(i) - rd_ptr_q[AW-1:0];
      if ({1'b0, slot_off} < count) mask[addr_mem[i]] = 1'b1;
    end
  end

  assign bus.b_ready      = !full;
  assign bus.W_addr       = waddr_q;
  assign bus.W_data       = wdata_q;
  assign bus.wr_enable    = wen_q;
  assign bus.pending_mask = mask;
  assign bus.fifo_count   = count;
  assign bus.stall_req    = stall_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [63:0] rf [32];

  regfile_wb_arbiter_if #(.width(64), .DEPTH(4)) bus ();

  regfile_wb_arbiter #(.width(64), .DEPTH(4), .STARVE_LIMIT(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.wr_enable) rf[bus.W_addr] <= bus.W_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_b(input logic [4:0] addr, input logic [63:0] data);
    bus.b_valid = 1'b1;
    bus.b_addr  = addr;
    bus.b_data  = data;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    push_b(5'h05, 64'h55);

    // 1: reset holds everything empty even with b_valid high
    step(); step(); step();
    check("rst_count", 64'(bus.fifo_count), 64'd0);
    bus.b_valid = 1'b0;
    reset = 1'b0;
    step();
    check("rst_wen",   64'(bus.wr_enable), 64'd0);
    check("rst_ready", 64'(bus.b_ready), 64'd1);
    check("rst_mask",  64'(bus.pending_mask), 64'd0);
    check("rst_stall", 64'(bus.stall_req), 64'd0);
    check("rst_waddr", 64'(bus.W_addr), 64'd0);
    check("rst_wdata", bus.W_data, 64'd0);

    // 2: A-only write
    bus.a_valid = 1'b1; bus.a_addr = 5'h01; bus.a_data = 64'hdeadbeef;
    step();
    bus.a_valid = 1'b0;
    check("a_waddr", 64'(bus.W_addr), 64'h01);
    check("a_wdata", bus.W_data, 64'hdeadbeef);
    check("a_wen",   64'(bus.wr_enable), 64'd1);
    step();
    check("a_rf1",   rf[1], 64'hdeadbeef);
    check("a_idle_wen",  64'(bus.wr_enable), 64'd0);
    check("a_hold_addr", 64'(bus.W_addr), 64'h01);

    // 3: B-only write, two-edge latency
    push_b(5'h15, 64'hcafebabe);
    step();
    bus.b_valid = 1'b0;
    check("b_mask",  64'(bus.pending_mask), 64'h0020_0000);
    check("b_count", 64'(bus.fifo_count), 64'd1);
    check("b_wen0",  64'(bus.wr_enable), 64'd0);
    step();
    check("b_waddr", 64'(bus.W_addr), 64'h15);
    check("b_wdata", bus.W_data, 64'hcafebabe);
    check("b_wen",   64'(bus.wr_enable), 64'd1);
    check("b_mask0", 64'(bus.pending_mask), 64'd0);

    // 4: A beats a queued B entry
    push_b(5'h14, 64'h1414);
    step();
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 5'h03; bus.a_data = 64'h33;
    step();
    bus.a_valid = 1'b0;
    check("cf_a_addr", 64'(bus.W_addr), 64'h03);
    check("cf_count",  64'(bus.fifo_count), 64'd1);
    check("cf_mask",   64'(bus.pending_mask), 64'h0010_0000);
    step();
    check("cf_b_addr", 64'(bus.W_addr), 64'h14);
    check("cf_b_data", bus.W_data, 64'h1414);
    check("cf_count0", 64'(bus.fifo_count), 64'd0);

    // 4b: simultaneous push and pop keeps count
    push_b(5'h0a, 64'haa);
    step();
    push_b(5'h0b, 64'hbb);
    step();
    bus.b_valid = 1'b0;
    check("pp_addr",  64'(bus.W_addr), 64'h0a);
    check("pp_count", 64'(bus.fifo_count), 64'd1);
    check("pp_mask",  64'(bus.pending_mask), 64'h0000_0800);
    step();
    check("pp_addr2", 64'(bus.W_addr), 64'h0b);

    // 5: fill under A pressure, starvation, drain
    bus.a_valid = 1'b1; bus.a_addr = 5'h02; bus.a_data = 64'h22;
    for (int k = 0; k < 4; k++) begin
      push_b(5'(5'h11 + k), 64'(64'h100 + k));
      step();
      check("fill_count", 64'(bus.fifo_count), 64'(k + 1));
    end
    check("fill_ready", 64'(bus.b_ready), 64'd0);
    check("fill_waddr", 64'(bus.W_addr), 64'h02);
    push_b(5'h1f, 64'hff);
    for (int k = 0; k < 4; k++) step();
    check("starve_pre", 64'(bus.stall_req), 64'd0);
    step();
    check("starve_stall", 64'(bus.stall_req), 64'd1);
    check("starve_count", 64'(bus.fifo_count), 64'd4);
    check("starve_mask",  64'(bus.pending_mask), 64'h001e_0000);
    check("starve_wen",   64'(bus.wr_enable), 64'd1);
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("drain_addr", 64'(bus.W_addr), 64'(5'h11 + k));
      check("drain_data", bus.W_data, 64'(64'h100 + k));
      check("drain_stall", 64'(bus.stall_req), 64'd0);
    end
    check("drain_count", 64'(bus.fifo_count), 64'd0);

    // 6: zero addresses are no-ops
    push_b(5'h00, 64'h99);
    bus.a_valid = 1'b1; bus.a_addr = 5'h00; bus.a_data = 64'h77;
    step();
    bus.b_valid = 1'b0; bus.a_valid = 1'b0;
    check("z_count", 64'(bus.fifo_count), 64'd0);
    check("z_wen",   64'(bus.wr_enable), 64'd0);
    push_b(5'h07, 64'h707);
    step();
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 5'h00;
    step();
    bus.a_valid = 1'b0;
    check("z_noblock_addr", 64'(bus.W_addr), 64'h07);
    check("z_noblock_wen",  64'(bus.wr_enable), 64'd1);

    // 6b: reset mid-drain
    bus.a_valid = 1'b1; bus.a_addr = 5'h02; bus.a_data = 64'h22;
    for (int k = 0; k < 3; k++) begin
      push_b(5'(5'h08 + k), 64'(k));
      step();
    end
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b0;
    step();
    check("md_addr",  64'(bus.W_addr), 64'h08);
    check("md_count", 64'(bus.fifo_count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check("md_rst_count", 64'(bus.fifo_count), 64'd0);
    check("md_rst_wen",   64'(bus.wr_enable), 64'd0);
    check("md_rst_mask",  64'(bus.pending_mask), 64'd0);
    check("md_rst_ready", 64'(bus.b_ready), 64'd1);
    check("md_rst_waddr", 64'(bus.W_addr), 64'd0);
    step();
    reset = 1'b0;
    step();
    check("md_post_count", 64'(bus.fifo_count), 64'd0);
    check("md_post_wen",   64'(bus.wr_enable), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
